// File: rtl/md_sequencer_if.sv
// rtl/md_sequencer_if.sv - ALU borrow bus between md_sequencer and the EX-stage ALU
// master is the sequencer (drives operands), slave is the ALU (returns result/carry).
interface md_sequencer_if;
   logic        alu_own_o;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic [3:0]  alu_aluc_o;
   logic [31:0] alu_r_i;
   logic        alu_carry_i;

   modport master (
      output alu_own_o, alu_a_o, alu_b_o, alu_aluc_o,
      input  alu_r_i, alu_carry_i
   );

   modport slave (
      input  alu_own_o, alu_a_o, alu_b_o, alu_aluc_o,
      output alu_r_i, alu_carry_i
   );
endinterface

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Time-shares the EX ALU: one add (multiply) or subtract (divide) per RUN cycle.
module md_sequencer #(
   parameter logic [3:0] ADDU_CODE = 4'b0000,
   parameter logic [3:0] SUBU_CODE = 4'b0001
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [31:0]       a_i,
   input  logic [31:0]       b_i,
   input  logic              flush_i,
   input  logic              hi_we_i,
   input  logic              lo_we_i,
   input  logic [31:0]       wdata_i,
   md_sequencer_if.master    alu,
   output logic              busy_o,
   output logic              done_o,
   output logic [31:0]       hi_o,
   output logic [31:0]       lo_o
);

   localparam int ITER = 32;
   localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        is_div_q, is_div_d;
   logic        sa_q, sa_d;
   logic        sb_q, sb_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] acc_q, acc_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [63:0] acc_neg;
   logic [31:0] div_r;
   logic [31:0] div_q;
   logic [31:0] div_p;
   logic        qbit;

   // Magnitudes come from local negation so the ALU stays free until RUN.
   assign abs_a   = sa_q ? (~a_q + 32'd1) : a_q;
   assign abs_b   = sb_q ? (~b_q + 32'd1) : b_q;
   assign acc_neg = ~acc_q + 64'd1;

   // Divide reuses ACC: upper half is the partial remainder, lower half the quotient.
   assign div_r = acc_q[63:32];
   assign div_q = acc_q[31:0];
   assign div_p = {div_r[30:0], div_q[31]};
   assign qbit  = div_r[31] | ~alu.alu_carry_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      is_div_d       = is_div_q;
      sa_d           = sa_q;
      sb_d           = sb_q;
      a_d            = a_q;
      b_d            = b_q;
      acc_d          = acc_q;
      cnt_d          = cnt_q;
      hi_d           = hi_q;
      lo_d           = lo_q;
      alu.alu_own_o  = 1'b0;
      alu.alu_a_o    = '0;
      alu.alu_b_o    = '0;
      alu.alu_aluc_o = ADDU_CODE;
      busy_o         = 1'b0;
      done_o         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               is_div_d = op_i[1];
               sa_d     = ~op_i[0] & a_i[31];
               sb_d     = ~op_i[0] & b_i[31];
               a_d      = a_i;
               b_d      = b_i;
               state_d  = S_PREP;
            end else begin
               if (hi_we_i) hi_d = wdata_i;
               if (lo_we_i) lo_d = wdata_i;
            end
         end

         S_PREP: begin
            busy_o = 1'b1;
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (is_div_q && (b_q == 32'd0)) begin
               hi_d    = a_q;
               lo_d    = 32'hFFFF_FFFF;
               state_d = S_DONE;
            end else begin
               cnt_d   = '0;
               acc_d   = is_div_q ? {32'h0, abs_a} : {32'h0, abs_b};
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            busy_o        = 1'b1;
            alu.alu_own_o = 1'b1;
            if (is_div_q) begin
               alu.alu_a_o    = div_p;
               alu.alu_b_o    = abs_b;
               alu.alu_aluc_o = SUBU_CODE;
            end else begin
               alu.alu_a_o    = acc_q[63:32];
               alu.alu_b_o    = acc_q[0] ? abs_a : 32'h0;
               alu.alu_aluc_o = ADDU_CODE;
            end
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               if (is_div_q)
                  acc_d = {(qbit ? alu.alu_r_i : div_p), div_q[30:0], qbit};
               else
                  acc_d = {alu.alu_carry_i, alu.alu_r_i, acc_q[31:1]};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == LAST_ITER) state_d = S_FIX;
            end
         end

         S_FIX: begin
            busy_o = 1'b1;
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               if (is_div_q) begin
                  lo_d = (sa_q ^ sb_q) ? (~div_q + 32'd1) : div_q;
                  hi_d = sa_q ? (~div_r + 32'd1) : div_r;
               end else if (sa_q ^ sb_q) begin
                  hi_d = acc_neg[63:32];
                  lo_d = acc_neg[31:0];
               end else begin
                  hi_d = acc_q[63:32];
                  lo_d = acc_q[31:0];
               end
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - scoreboard bench for md_sequencer with a behavioural ALU
// Stimulus pushes expected HI/LO; a monitor pops and compares on every done_o.
module tb_md_sequencer;

   localparam logic [3:0] ADDU = 4'b0000;
   localparam logic [3:0] SUBU = 4'b0001;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        flush_i;
   logic        hi_we_i;
   logic        lo_we_i;
   logic [31:0] wdata_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   md_sequencer_if alu_bus ();

   md_sequencer dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start_i),
      .op_i    (op_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .flush_i (flush_i),
      .hi_we_i (hi_we_i),
      .lo_we_i (lo_we_i),
      .wdata_i (wdata_i),
      .alu     (alu_bus),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o)
   );

   always #5 clk = ~clk;

   logic [32:0] alu_sum;
   always_comb begin
      alu_sum = {1'b0, alu_bus.alu_a_o} + {1'b0, alu_bus.alu_b_o};
      if (alu_bus.alu_aluc_o == SUBU) begin
         alu_bus.alu_r_i     = alu_bus.alu_a_o - alu_bus.alu_b_o;
         alu_bus.alu_carry_i = (alu_bus.alu_a_o < alu_bus.alu_b_o);
      end else begin
         alu_bus.alu_r_i     = alu_sum[31:0];
         alu_bus.alu_carry_i = alu_sum[32];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (done_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               check("hi_lo_result", {hi_o, lo_o}, exp_q.pop_front());
            end
         end
      end
   end

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int ek, input int eb, input int eo, input logic mthi);
      int k;
      int nbusy;
      int nown;
      logic seen;
      exp_q.push_back({eh, el});
      op_i    = op;
      a_i     = a;
      b_i     = b;
      start_i = 1'b1;
      if (mthi) begin
         hi_we_i = 1'b1;
         wdata_i = 32'h99;
      end
      tick();
      start_i = 1'b0;
      hi_we_i = 1'b0;
      if (mthi) check("mthi_with_start_ignored", {32'h0, hi_o}, 64'h0);
      k = 0;
      nbusy = 0;
      nown = 0;
      seen = 1'b0;
      while (!seen && k < 100) begin
         if (done_o) begin
            seen = 1'b1;
         end else begin
            nbusy += int'(busy_o);
            nown  += int'(alu_bus.alu_own_o);
            tick();
            k++;
         end
      end
      check("done_seen", {63'h0, seen}, 64'd1);
      check("done_latency", 64'(k), 64'(ek));
      check("busy_cycles", 64'(nbusy), 64'(eb));
      check("own_cycles", 64'(nown), 64'(eo));
      tick();
      check("done_one_cycle", {62'h0, done_o, busy_o}, 64'h0);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {hi_o, lo_o}, 64'h0);
      check({name, "_ctl"}, {60'h0, busy_o, done_o, alu_bus.alu_own_o, 1'b0}, 64'h0);
      check({name, "_alu"}, {alu_bus.alu_a_o, alu_bus.alu_b_o}, 64'h0);
      check({name, "_aluc"}, {60'h0, alu_bus.alu_aluc_o}, {60'h0, ADDU});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b0;
      start_i = 1'b0;
      op_i    = 2'b00;
      a_i     = '0;
      b_i     = '0;
      flush_i = 1'b0;
      hi_we_i = 1'b0;
      lo_we_i = 1'b0;
      wdata_i = '0;
      tick();
      tick();
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
      tick();

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 34, 32, 1'b0);
      run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 34, 32, 1'b0);
      run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34, 34, 32, 1'b0);
      run_op(OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 34, 34, 32, 1'b0);
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 34, 32, 1'b0);
      run_op(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 34, 32, 1'b0);
      run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34, 34, 32, 1'b0);
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 34, 32, 1'b0);
      run_op(OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001, 34, 34, 32, 1'b0);
      run_op(OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1, 1, 0, 1'b0);

      // Preload via MTHI/MTLO together, then abort a multiply in iteration 10.
      hi_we_i = 1'b1;
      lo_we_i = 1'b1;
      wdata_i = 32'h0000_AAAA;
      tick();
      lo_we_i = 1'b0;
      hi_we_i = 1'b0;
      lo_we_i = 1'b1;
      wdata_i = 32'h0000_5555;
      tick();
      lo_we_i = 1'b0;
      check("mthi_mtlo", {hi_o, lo_o}, {32'h0000_AAAA, 32'h0000_5555});
      op_i    = OP_MULTU;
      a_i     = 32'd5;
      b_i     = 32'd6;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 11; i++) tick();
      check("own_in_run", {63'h0, alu_bus.alu_own_o}, 64'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush_idle", {62'h0, busy_o, alu_bus.alu_own_o}, 64'h0);
      check("flush_hilo_kept", {hi_o, lo_o}, {32'h0000_AAAA, 32'h0000_5555});
      for (int i = 0; i < 40; i++) tick();
      hi_we_i = 1'b1;
      wdata_i = 32'h77;
      tick();
      hi_we_i = 1'b0;
      check("mthi_after_flush", {hi_o, lo_o}, {32'h0000_0077, 32'h0000_5555});

      // Reset in the middle of RUN iteration 20.
      op_i    = OP_MULTU;
      a_i     = 32'd9;
      b_i     = 32'd9;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 21; i++) tick();
      check("own_before_reset", {63'h0, alu_bus.alu_own_o}, 64'd1);
      rst_n = 1'b0;
      tick();
      check_reset_outputs("mid_run_reset");
      rst_n = 1'b1;
      run_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 34, 34, 32, 1'b1);

      for (int i = 0; i < 3; i++) tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Iterative multiply/divide controller for the static-pipe CPU's EX stage. Implements MULT/MULTU/DIV/DIVU by time-sharing the 32-bit ALU: one ALU add or subtract per cycle, sequenced by a small FSM. Owns the HI/LO registers. While an operation runs it takes the ALU away from the EX-stage mux and stalls the pipeline.

Parameters:
ADDU_CODE, 4'b0000, aluc value for 32-bit unsigned add; ALU carry = bit 32 of a+b.
SUBU_CODE, 4'b0001, aluc value for 32-bit unsigned subtract; ALU carry = 1 iff a<b unsigned (borrow).
ITER, 32, number of RUN iterations. Fixed to the ALU width; must not be overridden.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
start_i  input  1  request a new operation; sampled only in IDLE
op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a_i  input  32  rs operand (multiplicand / dividend)
b_i  input  32  rt operand (multiplier / divisor)
flush_i  input  1  abort the operation in flight
hi_we_i  input  1  MTHI write enable
lo_we_i  input  1  MTLO write enable
wdata_i  input  32  MTHI/MTLO data
alu_r_i  input  32  ALU result
alu_carry_i  input  1  ALU carry
alu_own_o  output  1  1 = EX ALU input mux selects this block's operands
alu_a_o  output  32  ALU operand a
alu_b_o  output  32  ALU operand b
alu_aluc_o  output  4  ALU opcode
busy_o  output  1  operation in progress; pipeline stall
done_o  output  1  one-cycle pulse; HI/LO hold the new result
hi_o  output  32  HI register
lo_o  output  32  LO register

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, hi_o=lo_o=0, busy_o=done_o=alu_own_o=0, alu_a_o=alu_b_o=0, alu_aluc_o=ADDU_CODE, all internal registers cleared. Reset overrides everything, including mid-operation.
- States: IDLE, PREP, RUN, FIX, DONE.
- busy_o=1 in PREP, RUN and FIX. alu_own_o=1 only in RUN. done_o=1 only in DONE.
- IDLE:
  - start_i=1: latch op_i, latch sa=a_i[31], sb=b_i[31] for signed ops (0 for unsigned ops), go to PREP. hi_we_i/lo_we_i in the same cycle are ignored.
  - Otherwise: hi_we_i writes HI, lo_we_i writes LO; both may be asserted together.
- PREP:
  - Signed ops: form |a| and |b| with local two's-complement logic, not the ALU. |0x80000000| = 0x80000000.
  - Divisor==0 (any divide): HI=a_i as latched, LO=32'hFFFFFFFF, go directly to DONE.
  - Otherwise: clear the iteration counter; multiply sets ACC={32'h0, |b|}, divide sets R=0, Q=|a|. Go to RUN.
- RUN, one iteration per cycle, ITER cycles:
  - Multiply: alu_a_o=ACC[63:32]; alu_b_o = ACC[0] ? |a| : 0; aluc=ADDU_CODE. Then ACC = {alu_carry_i, alu_r_i, ACC[31:1]}.
  - Divide:
    - P = {R[30:0], Q[31]}; alu_a_o=P; alu_b_o=|b|; aluc=SUBU_CODE.
    - qbit = R[31] | ~alu_carry_i.
    - R = qbit ? alu_r_i : P.
    - Q = {Q[30:0], qbit}.
  - After iteration ITER-1, go to FIX.
- FIX:
  - Multiply: if sa^sb, negate the 64-bit ACC. Then HI=ACC[63:32], LO=ACC[31:0].
  - Divide: LO = (sa^sb) ? -Q : Q; HI = sa ? -R : R.
  - Go to DONE.
- DONE: done_o=1 for one cycle, then IDLE. start_i is not accepted in DONE.
- Latency: start accepted at edge E0; HI/LO updated at E34; done_o high in the cycle after E34; busy_o low from E34. Divide-by-zero: HI/LO updated at E1, done_o high in the cycle after E1.
- Outside RUN: alu_a_o=alu_b_o=0, alu_aluc_o=ADDU_CODE.
- flush_i in PREP, RUN or FIX: go to IDLE at that edge; HI/LO unchanged; no done_o pulse. flush_i in IDLE or DONE has no effect.
- Special cases: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. hi_we_i/lo_we_i while busy are ignored.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done_o exactly 35 cycles after start; busy_o high 34 cycles; alu_own_o high exactly 32 cycles.
- MULT a=-3 (0xFFFFFFFD) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=100 b=7 -> LO=14, HI=2; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x1234 b=0 -> done_o 2 cycles after start; HI=0x1234, LO=0xFFFFFFFF; alu_own_o never asserts.
- Preload HI=0xAAAA/LO=0x5555 via MTHI/MTLO; start MULTU; assert flush_i in RUN iteration 10 -> IDLE next cycle, HI/LO still 0xAAAA/0x5555, no done_o. Then hi_we_i with wdata_i=0x77 -> HI=0x77.
- Drop rst_n in RUN iteration 20 -> next cycle all outputs at reset values; start_i and hi_we_i asserted together in IDLE -> operation starts and HI is not written.
